// File: rtl/tx_buff_seq_if.sv
// tx_buff_seq_if: host byte-stream handshake into the TX buffer load sequencer.
//   host_valid  host -> seq  byte on host_data is valid
//   host_data   host -> seq  frame byte (header bytes first, then data bytes)
//   host_ready  seq -> host  sequencer accepts a byte this cycle
interface tx_buff_seq_if;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_ready;
    modport master (output host_valid, output host_data, input host_ready);
    modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/tx_buff_seq.sv
// tx_buff_seq: loads a host frame into the CAN 10-slot TX buffer, requests transmission, retries and times out.
//   clk             system clock, rising edge
//   g_rst           synchronous active-low reset
//   host            byte handshake from the host (slave side)
//   abort_i         cancel the current frame
//   tx_buff_busy_i  TX buffer busy with a transmission
//   tx_success_i    pulse: frame transmitted and acknowledged
//   tx_error_i      pulse: arbitration loss or bus error
//   data_in_o       byte to the TX buffer
//   tx_buff_ld_o    one-hot slot load strobe, bit k-1 loads slot k
//   tx_start_o      one-cycle transmit request
//   frame_done_o    one-cycle pulse on success
//   frame_fail_o    one-cycle pulse on retry exhaustion, timeout or late abort
//   frame_len_o     slots used by the current frame
//   retry_cnt_o     retries issued for the current frame
module tx_buff_seq #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 2000
) (
    input  logic        clk,
    input  logic        g_rst,
    tx_buff_seq_if.slave host,
    input  logic        abort_i,
    input  logic        tx_buff_busy_i,
    input  logic        tx_success_i,
    input  logic        tx_error_i,
    output logic [7:0]  data_in_o,
    output logic [9:0]  tx_buff_ld_o,
    output logic        tx_start_o,
    output logic        frame_done_o,
    output logic        frame_fail_o,
    output logic [3:0]  frame_len_o,
    output logic [3:0]  retry_cnt_o
);
    typedef enum logic [2:0] {IDLE, HDR2, LOAD_DATA, START, WAIT_TX, BACKOFF} state_t;
    state_t      state_q;
    logic [3:0]  n_q;
    logic [3:0]  k_q;
    logic [15:0] tmo_q;
    logic        accept;
    logic [3:0]  n_hdr;
    // Ready is gated by g_rst so nothing is accepted on a reset edge.
    assign host.host_ready = g_rst & (state_q inside {IDLE, HDR2, LOAD_DATA}) & ~tx_buff_busy_i & ~abort_i;
    assign accept = host.host_valid & host.host_ready;
    // Second header byte is {ID[2:0], RTR, DLC}; RTR frames carry no data, DLC above 8 clamps to 8.
    assign n_hdr = host.host_data[4] ? 4'd0 : host.host_data[3] ? 4'd8 : {1'b0, host.host_data[2:0]};
    always_ff @(posedge clk) begin
        if (!g_rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            k_q          <= '0;
            tmo_q        <= '0;
            data_in_o    <= '0;
            tx_buff_ld_o <= '0;
            tx_start_o   <= 1'b0;
            frame_done_o <= 1'b0;
            frame_fail_o <= 1'b0;
            frame_len_o  <= '0;
            retry_cnt_o  <= '0;
        end else begin
            tx_buff_ld_o <= '0;
            tx_start_o   <= 1'b0;
            frame_done_o <= 1'b0;
            frame_fail_o <= 1'b0;
            if (accept) data_in_o <= host.host_data;
            if (abort_i && state_q != IDLE) begin
                state_q      <= IDLE;
                frame_fail_o <= state_q inside {WAIT_TX, BACKOFF};
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        tx_buff_ld_o <= 10'd1;
                        retry_cnt_o  <= '0;
                        state_q      <= HDR2;
                    end
                    HDR2: if (accept) begin
                        tx_buff_ld_o <= 10'd2;
                        n_q          <= n_hdr;
                        k_q          <= '0;
                        frame_len_o  <= 4'd2 + n_hdr;
                        state_q      <= n_hdr == 4'd0 ? START : LOAD_DATA;
                    end
                    LOAD_DATA: if (accept) begin
                        tx_buff_ld_o <= 10'd4 << k_q;
                        k_q          <= k_q + 4'd1;
                        if (k_q + 4'd1 == n_q) state_q <= START;
                    end
                    START: begin
                        tx_start_o <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        tmo_q <= tmo_q + 16'd1;
                        if (tx_success_i) begin
                            frame_done_o <= 1'b1;
                            state_q      <= IDLE;
                        end else if (tx_error_i) begin
                            if (retry_cnt_o == 4'(MAX_RETRY)) begin
                                frame_fail_o <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                retry_cnt_o <= retry_cnt_o + 4'd1;
                                state_q     <= BACKOFF;
                            end
                        end else if (tmo_q + 16'd1 == 16'(TIMEOUT)) begin
                            frame_fail_o <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    // Slot contents are still valid in the buffer, so a retry only re-requests transmission.
                    BACKOFF: if (!tx_buff_busy_i) state_q <= START;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tx_buff_seq.sv
// tb_tx_buff_seq: scoreboard bench for tx_buff_seq; stimulus pushes expected output events, a monitor pops and compares.
//   Drives the host interface, abort/busy/success/error pulses; observes all DUT outputs.
module tb_tx_buff_seq;
    localparam int TO = 12;
    typedef struct {
        logic [9:0] ld;
        logic [7:0] data;
        logic       start;
        logic       done;
        logic       fail;
        logic [3:0] len;
        logic [3:0] retry;
        int         gap;
    } ev_t;
    logic       clk = 1'b0;
    logic       g_rst;
    logic       abort_i, tx_buff_busy_i, tx_success_i, tx_error_i;
    logic [7:0] data_in_o;
    logic [9:0] tx_buff_ld_o;
    logic       tx_start_o, frame_done_o, frame_fail_o;
    logic [3:0] frame_len_o, retry_cnt_o;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last = 0;
    ev_t        exp_q[$];
    tx_buff_seq_if hif();
    tx_buff_seq #(.MAX_RETRY(3), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .g_rst          (g_rst),
        .host           (hif),
        .abort_i        (abort_i),
        .tx_buff_busy_i (tx_buff_busy_i),
        .tx_success_i   (tx_success_i),
        .tx_error_i     (tx_error_i),
        .data_in_o      (data_in_o),
        .tx_buff_ld_o   (tx_buff_ld_o),
        .tx_start_o     (tx_start_o),
        .frame_done_o   (frame_done_o),
        .frame_fail_o   (frame_fail_o),
        .frame_len_o    (frame_len_o),
        .retry_cnt_o    (retry_cnt_o)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
    // Monitor: every cycle with a strobe or pulse is an output event matched against the queue head.
    initial begin
        ev_t e;
        int  g;
        bit  ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_buff_ld_o != 0 || tx_start_o || frame_done_o || frame_fail_o) begin
                g = cyc - last;
                last = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: ld=%h data=%h start=%b done=%b fail=%b, required no event", tx_buff_ld_o, data_in_o, tx_start_o, frame_done_o, frame_fail_o);
                end else begin
                    e = exp_q.pop_front();
                    ok = tx_buff_ld_o == e.ld && tx_start_o == e.start && frame_done_o == e.done && frame_fail_o == e.fail
                         && (e.ld == 0 || data_in_o == e.data)
                         && (e.ld != 0 || (frame_len_o == e.len && retry_cnt_o == e.retry))
                         && (e.gap < 0 || g == e.gap);
                    if (!ok) begin
                        failures++;
                        $display("FAIL event%0d: got ld=%h data=%h s/d/f=%b%b%b len=%0d retry=%0d gap=%0d, required ld=%h data=%h s/d/f=%b%b%b len=%0d retry=%0d gap=%0d",
                                 checks, tx_buff_ld_o, data_in_o, tx_start_o, frame_done_o, frame_fail_o, frame_len_o, retry_cnt_o, g,
                                 e.ld, e.data, e.start, e.done, e.fail, e.len, e.retry, e.gap);
                    end
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask
    task automatic exp_ld(input logic [9:0] ld, input logic [7:0] d, input int g);
        ev_t e;
        e.ld = ld; e.data = d; e.start = 0; e.done = 0; e.fail = 0; e.len = 0; e.retry = 0; e.gap = g;
        exp_q.push_back(e);
    endtask
    task automatic exp_ctl(input logic s, input logic dn, input logic f, input logic [3:0] len, input logic [3:0] r, input int g);
        ev_t e;
        e.ld = '0; e.data = '0; e.start = s; e.done = dn; e.fail = f; e.len = len; e.retry = r; e.gap = g;
        exp_q.push_back(e);
    endtask
    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        hif.host_valid = 1'b1;
        hif.host_data  = d;
        #1;
        while (!hif.host_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!hif.host_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait: host_ready stayed 0 for byte %h, required 1", d);
        end
        @(posedge clk);
    endtask
    task automatic stop_send();
        @(negedge clk);
        hif.host_valid = 1'b0;
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse(input logic s, input logic e, input logic a);
        tx_success_i = s;
        tx_error_i   = e;
        abort_i      = a;
        @(negedge clk);
        tx_success_i = 1'b0;
        tx_error_i   = 1'b0;
        abort_i      = 1'b0;
    endtask
    initial begin
        g_rst = 1'b0;
        hif.host_valid = 1'b1;
        hif.host_data  = 8'h55;
        abort_i = 1'b0; tx_buff_busy_i = 1'b0; tx_success_i = 1'b0; tx_error_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ld", 32'(tx_buff_ld_o), 0);
        chk("rst_data", 32'(data_in_o), 0);
        chk("rst_pulses", {29'd0, tx_start_o, frame_done_o, frame_fail_o}, 0);
        chk("rst_len", 32'(frame_len_o), 0);
        chk("rst_retry", 32'(retry_cnt_o), 0);
        chk("rst_ready", 32'(hif.host_ready), 0);
        hif.host_valid = 1'b0;
        g_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(hif.host_ready), 1);
        pulse(1, 1, 0);
        pulse(0, 0, 1);
        cycles(2);
        // Data frame, DLC 2
        exp_ld(10'h001, 8'hAA, -1);
        exp_ld(10'h002, 8'h02, 1);
        exp_ld(10'h004, 8'hCC, 1);
        exp_ld(10'h008, 8'hAB, 1);
        exp_ctl(1, 0, 0, 4, 0, 1);
        send(8'hAA); send(8'h02); send(8'hCC); send(8'hAB);
        stop_send();
        cycles(2);
        exp_ctl(0, 1, 0, 4, 0, 2);
        pulse(1, 0, 0);
        cycles(3);
        // RTR frame: header only
        exp_ld(10'h001, 8'h12, -1);
        exp_ld(10'h002, 8'h18, 1);
        exp_ctl(1, 0, 0, 2, 0, 1);
        send(8'h12); send(8'h18);
        stop_send();
        cycles(2);
        exp_ctl(0, 1, 0, 2, 0, 2);
        pulse(1, 0, 0);
        cycles(3);
        // DLC 15 clamps to 8 data bytes
        exp_ld(10'h001, 8'h12, -1);
        exp_ld(10'h002, 8'h0F, 1);
        for (int i = 0; i < 8; i++) exp_ld(10'(10'd4 << i), 8'(8'h30 + i), 1);
        exp_ctl(1, 0, 0, 10, 0, 1);
        send(8'h12); send(8'h0F);
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
        stop_send();
        cycles(2);
        exp_ctl(0, 1, 0, 10, 0, 2);
        pulse(1, 0, 0);
        cycles(3);
        // Retry exhaustion, including a retry held back by a busy buffer
        exp_ld(10'h001, 8'h21, -1);
        exp_ld(10'h002, 8'h01, 1);
        exp_ld(10'h004, 8'h5A, 1);
        exp_ctl(1, 0, 0, 3, 0, 1);
        send(8'h21); send(8'h01); send(8'h5A);
        stop_send();
        cycles(1);
        exp_ctl(1, 0, 0, 3, 1, 3);
        pulse(0, 1, 0);
        cycles(2);
        exp_ctl(1, 0, 0, 3, 2, 7);
        tx_buff_busy_i = 1'b1;
        pulse(0, 1, 0);
        cycles(4);
        tx_buff_busy_i = 1'b0;
        cycles(2);
        exp_ctl(1, 0, 0, 3, 3, 3);
        pulse(0, 1, 0);
        cycles(2);
        exp_ctl(0, 0, 1, 3, 3, 1);
        pulse(0, 1, 0);
        cycles(3);
        // Timeout with no response
        exp_ld(10'h001, 8'h33, -1);
        exp_ld(10'h002, 8'h10, 1);
        exp_ctl(1, 0, 0, 2, 0, 1);
        exp_ctl(0, 0, 1, 2, 0, TO);
        send(8'h33); send(8'h10);
        stop_send();
        cycles(TO + 4);
        // Simultaneous success and error
        exp_ld(10'h001, 8'h44, -1);
        exp_ld(10'h002, 8'h10, 1);
        exp_ctl(1, 0, 0, 2, 0, 1);
        exp_ctl(0, 1, 0, 2, 0, 1);
        send(8'h44); send(8'h10);
        stop_send();
        cycles(1);
        pulse(1, 1, 0);
        cycles(3);
        // Abort during data load: no strobe, no fail
        exp_ld(10'h001, 8'h55, -1);
        exp_ld(10'h002, 8'h03, 1);
        exp_ld(10'h004, 8'h01, 1);
        send(8'h55); send(8'h03); send(8'h01);
        @(negedge clk);
        hif.host_data = 8'hEE;
        abort_i = 1'b1;
        #1;
        chk("ready_during_abort", 32'(hif.host_ready), 0);
        @(negedge clk);
        abort_i = 1'b0;
        hif.host_valid = 1'b0;
        cycles(3);
        // Next frame restarts at slot 1, then abort in WAIT_TX fails it
        exp_ld(10'h001, 8'h66, -1);
        exp_ld(10'h002, 8'h10, 1);
        exp_ctl(1, 0, 0, 2, 0, 1);
        exp_ctl(0, 0, 1, 2, 0, 1);
        send(8'h66); send(8'h10);
        stop_send();
        cycles(1);
        pulse(0, 0, 1);
        cycles(5);
        chk("drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
